div_n36: RTL and testbench

Sequential divide-by-minus-36 unit. It is the inverse of the ×(−36) multiplier in the filter datapath. It accepts a 24-bit two's-complement product and returns the 16-bit unsigned operand that produced it, together with a signed remainder and status flags. It uses a one-bit-per-cycle restoring division on the magnitude, with valid/ready handshakes on both sides. Round trip: div_n36(xn36(x)) returns x with exact=1 for every 16-bit x.

---
 rtl/div_n36_pkg.sv | 9 +
 rtl/div36_step.sv | 19 +
 rtl/div_n36.sv | 85 ++++++++
 tb/tb_div_n36.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div_n36_pkg.sv
// div_n36_pkg: shared constants and state type for the divide-by-minus-36 unit
package div_n36_pkg;
  localparam int DIVISOR = 36;
  localparam int DIN_W   = 24;
  localparam int Q_W     = 16;
  localparam int REM_W   = 7;
  localparam int CNT_W   = 5;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/div36_step.sv
// div36_step: one restoring-division step by 36 on a 6-bit partial remainder
module div36_step
  import div_n36_pkg::*;
(
  input  logic [5:0] rem_i,
  input  logic       bit_i,
  output logic [5:0] rem_o,
  output logic       q_o
);
  logic [REM_W-1:0] r;
  logic [REM_W-1:0] r_sub;
  // shift in the next dividend bit and subtract 36 when it fits
  always_comb begin
    r     = {rem_i, bit_i};
    r_sub = r - REM_W'(DIVISOR);
    q_o   = r >= REM_W'(DIVISOR);
    rem_o = q_o ? r_sub[5:0] : r[5:0];
  end
endmodule

// File: rtl/div_n36.sv
// div_n36: sequential divide-by-(-36), restoring division on the dividend magnitude
module div_n36
  import div_n36_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   quotient,
  output logic [REM_W-1:0] remainder,
  output logic             exact,
  output logic             range_err
);
  state_e           state_q;
  logic             neg_q;
  logic [DIN_W-1:0] mag_q;
  logic [5:0]       rem_q;
  logic [5:0]       rem_d;
  logic [DIN_W-1:0] qacc_q;
  logic [DIN_W-1:0] qacc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             qbit;

  div36_step u_step (
    .rem_i (rem_q),
    .bit_i (mag_q[cnt_q]),
    .rem_o (rem_d),
    .q_o   (qbit)
  );

  // quotient bits arrive MSB first, so shifting in from the bottom lands each at qacc[cnt]
  always_comb begin
    qacc_d   = {qacc_q[DIN_W-2:0], qbit};
    in_ready = state_q == IDLE;
  end

  // FSM with capture, iteration and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      neg_q     <= 1'b0;
      mag_q     <= '0;
      rem_q     <= '0;
      qacc_q    <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      exact     <= 1'b0;
      range_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          neg_q   <= data_in[DIN_W-1];
          mag_q   <= data_in[DIN_W-1] ? -data_in : data_in;
          rem_q   <= '0;
          qacc_q  <= '0;
          cnt_q   <= CNT_W'(DIN_W - 1);
          state_q <= CALC;
        end
        CALC: begin
          rem_q  <= rem_d;
          qacc_q <= qacc_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
            quotient  <= qacc_d[Q_W-1:0];
            remainder <= neg_q ? -{1'b0, rem_d} : {1'b0, rem_d};
            exact     <= rem_d == '0;
            range_err <= (|qacc_d[DIN_W-1:Q_W]) | (!neg_q & (qacc_d != '0));
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_n36.sv
// tb_div_n36: randomized and directed self-checking bench for div_n36
module tb_div_n36;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [23:0] data_in = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] quotient;
  logic [6:0]  remainder;
  logic        exact;
  logic        range_err;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct {
    logic [15:0] q;
    logic [6:0]  r;
    logic        ex;
    logic        re;
  } res_t;

  div_n36 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .exact     (exact),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic res_t model(input logic [23:0] d);
    res_t   e;
    longint v = longint'($signed(d));
    bit     neg = v < 0;
    longint m = neg ? -v : v;
    longint q = m / 36;
    longint r = m % 36;
    e.q  = q[15:0];
    e.r  = neg ? 7'(-r) : 7'(r);
    e.ex = r == 0;
    e.re = (q > 65535) || (!neg && q != 0);
    return e;
  endfunction

  task automatic send(input logic [23:0] d);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1;
    data_in  = d;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 24);
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_q"}, quotient, e.q);
    chk({tag, "_r"}, remainder, e.r);
    chk({tag, "_exact"}, exact, e.ex);
    chk({tag, "_rerr"}, range_err, e.re);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  task automatic xact(input string tag, input logic [23:0] d, input res_t e);
    send(d);
    wait_result(tag);
    chk_res(tag, e);
    handshake(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_q"}, quotient, 0);
    chk({tag, "_r"}, remainder, 0);
    chk({tag, "_exact"}, exact, 0);
    chk({tag, "_rerr"}, range_err, 0);
  endtask

  initial begin
    res_t e;
    logic [23:0] d;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);

    xact("d1234", 24'(-44424), '{16'd1234, 7'd0, 1'b1, 1'b0});
    xact("dm37", 24'(-37), '{16'd1, 7'h7F, 1'b0, 1'b0});
    xact("d17", 24'd17, '{16'd0, 7'd17, 1'b0, 1'b0});
    xact("dmin", 24'h800000, '{16'h8E38, 7'h60, 1'b0, 1'b1});
    xact("d72", 24'd72, '{16'd2, 7'd0, 1'b1, 1'b1});
    xact("dzero", 24'd0, '{16'd0, 7'd0, 1'b1, 1'b0});
    xact("dmax", 24'(-36 * 65535), '{16'hFFFF, 7'd0, 1'b1, 1'b0});

    send(24'(-36 * 500));
    wait_result("bp");
    in_valid = 1;
    data_in  = 24'(-36 * 777 - 5);
    for (int i = 0; i < 10; i++) begin
      chk_res("bp_hold", '{16'd500, 7'd0, 1'b1, 1'b0});
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    chk("bp_accepted", in_ready, 0);
    wait_result("bp_pend");
    chk_res("bp_pend", '{16'd777, 7'h7B, 1'b0, 1'b0});
    handshake("bp_pend");

    send(24'(-36 * 999 - 7));
    repeat (9) @(negedge clk);
    rst_n = 0;
    #1;
    chk_zero("rst_calc");
    @(negedge clk);
    rst_n = 1;
    xact("after_rst", 24'(-36 * 42), '{16'd42, 7'd0, 1'b1, 1'b0});

    send(24'(-36 * 4321 - 3));
    wait_result("rst_done_pre");
    rst_n = 0;
    #1;
    chk_zero("rst_done");
    @(negedge clk);
    rst_n = 1;
    xact("after_rst2", 24'd35, '{16'd0, 7'd35, 1'b0, 1'b0});

    for (int i = 0; i < 300; i++) begin
      int x = int'($urandom_range(0, 65535));
      d = 24'(-36 * x);
      send(d);
      wait_result("rt");
      chk_res("rt", '{16'(x), 7'd0, 1'b1, 1'b0});
      handshake("rt");
    end

    for (int i = 0; i < 200; i++) begin
      d = 24'($urandom);
      e = model(d);
      send(d);
      wait_result("rnd");
      chk_res("rnd", e);
      if (($urandom & 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      handshake("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
